// File: rtl/inst_fetch_responder_pkg.sv
// Shared constants and state encoding for the instruction-fetch responder.
// Imported by the top level and the timeout counter.
package inst_fetch_responder_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic RST_ASSERTED = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_responder_timeout_ctr.sv
// Saturating cycle counter that bounds how long a memory request may stay open.
// expired_o rises once TIMEOUT-1 cycles have been counted since the last clear.
module fetch_timeout_ctr
  import inst_fetch_responder_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: one-entry fetch buffer in front of a handshaked
// instruction-memory bus, with stall request, flush and timeout handling.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stallreq_o,
  output logic              fetch_err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  fetch_state_e      state_q, state_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fetch_err_q, fetch_err_d;

  logic hit, miss_req, expired, ctr_clear, ctr_en;

  assign hit        = ce_i & buf_valid_q & (buf_addr_q == pc_i);
  assign miss_req   = ce_i & ~hit & ~flush_i;
  assign inst_o     = hit ? buf_data_q : NOP_INST;
  assign stallreq_o = miss_req ? STOP : NO_STOP;

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign fetch_err_o = fetch_err_q;

  // Counts through DRAIN as well, so a flushed request is bounded by the same budget.
  assign ctr_en = (state_q != IDLE);

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (ctr_clear),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fetch_err_d = 1'b0;
    ctr_clear   = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          buf_valid_d = 1'b0;
        end else if (miss_req) begin
          if (pc_i[1:0] == 2'b00) begin
            mem_addr_d = pc_i;
            mem_req_d  = 1'b1;
            ctr_clear  = 1'b1;
            state_d    = BUSY;
          end else begin
            // Misaligned pc: buffer a NOP so the next cycle hits and the stall releases.
            buf_addr_d  = pc_i;
            buf_data_d  = NOP_INST;
            buf_valid_d = 1'b1;
            fetch_err_d = 1'b1;
          end
        end
      end

      BUSY: begin
        if (flush_i) begin
          buf_valid_d = 1'b0;
          if (mem_ack_i || expired) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack_i) begin
          buf_addr_d  = mem_addr_q;
          buf_data_d  = mem_rdata_i;
          buf_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end else if (expired) begin
          buf_addr_d  = mem_addr_q;
          buf_data_d  = NOP_INST;
          buf_valid_d = 1'b1;
          fetch_err_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end

      DRAIN: begin
        if (flush_i) begin
          buf_valid_d = 1'b0;
        end
        if (mem_ack_i || expired) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= NOP_INST;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

endmodule
